// File: rtl/piso_shift_reg_pkg.sv
// rtl/piso_shift_reg_pkg.sv - state encoding and frame constants shared by the PISO transmitter
package piso_shift_reg_pkg;

  // Frame width shared with the SIPO receiver on the other end of the link
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_shift_reg_if.sv
// rtl/piso_shift_reg_if.sv - load handshake and serial output bundle of the PISO transmitter
interface piso_shift_reg_if #(
  parameter int WIDTH = piso_shift_reg_pkg::DEFAULT_WIDTH
);
  logic             LOAD_VALID;
  logic [WIDTH-1:0] DIN;
  logic             LOAD_READY;
  logic             SER;
  logic             SER_VALID;
  logic             DONE;

  modport master (
    output LOAD_VALID, DIN,
    input  LOAD_READY, SER, SER_VALID, DONE
  );

  modport slave (
    input  LOAD_VALID, DIN,
    output LOAD_READY, SER, SER_VALID, DONE
  );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in/serial-out transmitter, one bit per clock with DONE pulse
// Optional even parity bit after the data bits when PISO_PARITY_EN is defined.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            Clk,
  input  logic            RST,
  piso_shift_reg_if.slave bus
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ser_bit;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.LOAD_VALID) begin
          state_d  = ST_SHIFT;
          shreg_d  = bus.DIN;
          cnt_d    = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^bus.DIN;
`endif
        end
      end
      ST_SHIFT: begin
        // Shift toward the output end so the next bit is always at the same tap
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ser_bit = 1'b0;
    case (state_q)
      ST_SHIFT:  ser_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef PISO_PARITY_EN
      ST_PARITY: ser_bit = parity_q;
`endif
      default:   ser_bit = 1'b0;
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just at the reset edge
  assign bus.LOAD_READY = RST & (state_q == ST_IDLE);
  assign bus.SER_VALID  = RST & ((state_q == ST_SHIFT) | (state_q == ST_PARITY));
  assign bus.SER        = RST & ser_bit;
  assign bus.DONE       = RST & done_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb/tb_piso_shift_reg.sv - self-checking bench for piso_shift_reg (MSB/LSB instances, SIPO loopback)
module tb_piso_shift_reg;
  import piso_shift_reg_pkg::*;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic Clk = 1'b0;
  logic RST = 1'b0;
  always #5 Clk = ~Clk;

  piso_shift_reg_if #(.WIDTH(W)) if_m ();
  piso_shift_reg_if #(.WIDTH(W)) if_l ();

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.Clk(Clk), .RST(RST), .bus(if_m));
  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.Clk(Clk), .RST(RST), .bus(if_l));

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  // SIPO receiver model, MSB-first, takes only the data bits of each frame
  logic [W-1:0] rx_q;
  int           rcnt;
  always @(posedge Clk) begin
    if (!RST) begin
      rcnt <= 0;
      rx_q <= '0;
    end else if (if_m.SER_VALID && rcnt < W) begin
      rx_q <= {rx_q[W-2:0], if_m.SER};
      rcnt <= rcnt + 1;
    end else if (if_m.DONE) begin
      rcnt <= 0;
    end
  end

  task automatic test_reset();
    RST = 1'b0;
    if_m.LOAD_VALID = 1'b1; if_m.DIN = 8'hA5;
    if_l.LOAD_VALID = 1'b1; if_l.DIN = 8'hA5;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({if_m.LOAD_READY, if_m.SER, if_m.SER_VALID, if_m.DONE} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs_msb got=%b exp=0000", {if_m.LOAD_READY, if_m.SER, if_m.SER_VALID, if_m.DONE});
    end
    checks++;
    if ({if_l.LOAD_READY, if_l.SER, if_l.SER_VALID, if_l.DONE} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs_lsb got=%b exp=0000", {if_l.LOAD_READY, if_l.SER, if_l.SER_VALID, if_l.DONE});
    end
    if_m.LOAD_VALID = 1'b0;
    if_l.LOAD_VALID = 1'b0;
    RST = 1'b1;
    #1;
    checks++;
    if (if_m.LOAD_READY !== 1'b1 || if_l.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b%b exp=11", if_m.LOAD_READY, if_l.LOAD_READY);
    end
  endtask

  task automatic test_frame_msb(input logic [W-1:0] d);
    logic e;
    @(negedge Clk);
    checks++;
    if (if_m.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL msb_ready_idle got=%b exp=1", if_m.LOAD_READY);
    end
    if_m.DIN = d;
    if_m.LOAD_VALID = 1'b1;
    for (int i = 0; i < W; i++) exp_q.push_back(d[W-1-i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^d);
`endif
    @(negedge Clk);
    if_m.LOAD_VALID = 1'b0;
    if_m.DIN = ~d;
    for (int i = 0; i < FL; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (if_m.SER_VALID !== 1'b1 || if_m.SER !== e || if_m.DONE !== 1'b0) begin
        failures++;
        $display("FAIL msb_bit din=%h bit=%0d got ser=%b v=%b done=%b exp ser=%b v=1 done=0",
                 d, i, if_m.SER, if_m.SER_VALID, if_m.DONE, e);
      end
      @(negedge Clk);
    end
    checks++;
    if (if_m.DONE !== 1'b1 || if_m.LOAD_READY !== 1'b1 || if_m.SER_VALID !== 1'b0) begin
      failures++;
      $display("FAIL msb_done din=%h got done=%b ready=%b v=%b exp 1 1 0",
               d, if_m.DONE, if_m.LOAD_READY, if_m.SER_VALID);
    end
    @(negedge Clk);
    checks++;
    if (if_m.DONE !== 1'b0) begin
      failures++;
      $display("FAIL msb_done_pulse din=%h got=%b exp=0", d, if_m.DONE);
    end
  endtask

  task automatic test_lsb_ignore();
    logic e;
    @(negedge Clk);
    if_l.DIN = 8'h01;
    if_l.LOAD_VALID = 1'b1;
    for (int i = 0; i < W; i++) exp_q.push_back(i == 0);
`ifdef PISO_PARITY_EN
    exp_q.push_back(1'b1);
`endif
    @(negedge Clk);
    if_l.DIN = 8'hFF;
    for (int i = 0; i < FL; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (if_l.SER_VALID !== 1'b1 || if_l.SER !== e || if_l.LOAD_READY !== 1'b0) begin
        failures++;
        $display("FAIL lsb_bit bit=%0d got ser=%b v=%b ready=%b exp ser=%b v=1 ready=0",
                 i, if_l.SER, if_l.SER_VALID, if_l.LOAD_READY, e);
      end
      @(negedge Clk);
    end
    checks++;
    if (if_l.DONE !== 1'b1 || if_l.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL lsb_done got done=%b ready=%b exp 1 1", if_l.DONE, if_l.LOAD_READY);
    end
    @(negedge Clk);
    if_l.LOAD_VALID = 1'b0;
    checks++;
    if (if_l.SER_VALID !== 1'b1 || if_l.SER !== 1'b1 || if_l.DONE !== 1'b0) begin
      failures++;
      $display("FAIL lsb_held_accept got ser=%b v=%b done=%b exp 1 1 0", if_l.SER, if_l.SER_VALID, if_l.DONE);
    end
    for (int n = 0; n < FL + 4 && !if_l.LOAD_READY; n++) @(negedge Clk);
    checks++;
    if (if_l.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL lsb_drain_timeout got ready=%b exp=1", if_l.LOAD_READY);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_midframe();
    int done_seen;
    @(negedge Clk);
    if_m.DIN = 8'h3C;
    if_m.LOAD_VALID = 1'b1;
    @(negedge Clk);
    if_m.LOAD_VALID = 1'b0;
    repeat (4) @(negedge Clk);
    checks++;
    if (if_m.SER_VALID !== 1'b1 || if_m.SER !== 1'b1) begin
      failures++;
      $display("FAIL midrst_bit4 got ser=%b v=%b exp 1 1", if_m.SER, if_m.SER_VALID);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({if_m.LOAD_READY, if_m.SER, if_m.SER_VALID, if_m.DONE} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_outputs got=%b exp=0000", {if_m.LOAD_READY, if_m.SER, if_m.SER_VALID, if_m.DONE});
    end
    @(negedge Clk);
    RST = 1'b1;
    done_seen = 0;
    for (int n = 0; n < FL + 2; n++) begin
      #1;
      if (if_m.DONE || if_m.SER_VALID) done_seen++;
      @(negedge Clk);
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL midrst_no_done got=%0d active cycles exp=0", done_seen);
    end
    test_frame_msb(8'hC3);
  endtask

  task automatic test_loopback();
    logic [W-1:0] words[$];
    logic [W-1:0] w;
    logic [W-1:0] exp_w;
    int sent = 0;
    int got  = 0;
    for (int n = 0; n < 50 * (FL + 1) + 60 && got < 50; n++) begin
      @(negedge Clk);
      if (if_m.DONE && words.size() > 0) begin
        exp_w = words.pop_front();
        checks++;
        if (rx_q !== exp_w) begin
          failures++;
          $display("FAIL loopback word=%0d got=%h exp=%h", got, rx_q, exp_w);
        end
        got++;
      end
      if (if_m.LOAD_READY && sent < 50) begin
        w = W'($urandom);
        if_m.DIN = w;
        if_m.LOAD_VALID = 1'b1;
        words.push_back(w);
        sent++;
      end else begin
        if_m.LOAD_VALID = 1'b0;
      end
    end
    if_m.LOAD_VALID = 1'b0;
    checks++;
    if (got !== 50) begin
      failures++;
      $display("FAIL loopback_count got=%0d exp=50", got);
    end
  endtask

  initial begin
    if_m.LOAD_VALID = 1'b0; if_m.DIN = '0;
    if_l.LOAD_VALID = 1'b0; if_l.DIN = '0;
    test_reset();
    test_frame_msb(8'hA5);
    test_frame_msb(8'h07);
    test_lsb_ignore();
    test_reset_midframe();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
